mxn_valid_pipeline: RTL and testbench

MXN_VALID_PIPELINE -- requirements
Module: mxn_valid_pipeline

---
 rtl/mxn_valid_pipeline.sv | 73 +++++++
 tb/tb_mxn_valid_pipeline.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mxn_valid_pipeline.sv
// Per-channel valid/data delay line with a selectable output tap and an occupancy count.
// Latency: effective tap (1..DEPTH) enabled edges; the output is a combinational tap mux.
// Backpressure: none; en=0 freezes every stage and drops that cycle's input, flush clears valids.
module mxn_valid_pipeline #(
    parameter int WIDTH     = 3,
    parameter int DEPTH     = 4,
    parameter int CHANNELS  = 2,
    localparam int LW       = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      flush,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS*LW-1:0]    lat_sel,
    output logic [CHANNELS-1:0]       out_valid,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic [CHANNELS*LW-1:0]    inflight
);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        // Index 0 is stage 1 (newest entry), index DEPTH-1 is stage DEPTH.
        logic [WIDTH-1:0] stage_dat [DEPTH];
        logic [DEPTH-1:0] stage_vld;
        logic [LW-1:0]    cnt_q;
        logic [LW-1:0]    sel;
        logic             tap_vld;
        logic [WIDTH-1:0] tap_dat;

        assign sel = lat_sel[c*LW +: LW];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int k = 0; k < DEPTH; k++) begin
                    stage_dat[k] <= '0;
                end
                stage_vld <= '0;
                cnt_q     <= '0;
            end else if (flush) begin
                stage_vld <= '0;
                cnt_q     <= '0;
            end else if (en) begin
                stage_dat[0] <= in_data[c*WIDTH +: WIDTH];
                for (int k = 1; k < DEPTH; k++) begin
                    stage_dat[k] <= stage_dat[k-1];
                end
                stage_vld <= (stage_vld << 1) | DEPTH'(in_valid[c]);
                // Tracks the popcount of stage_vld, so it stays within 0..DEPTH.
                cnt_q     <= cnt_q + LW'(in_valid[c]) - LW'(stage_vld[DEPTH-1]);
            end
        end

        // Tap 0 aliases stage 1 and out-of-range taps clamp to the last stage.
        always_comb begin
            tap_vld = 1'b0;
            tap_dat = '0;
            for (int k = 0; k < DEPTH; k++) begin
                if ((32'(sel) == k + 1) ||
                    (k == 0 && sel == '0) ||
                    (k == DEPTH - 1 && 32'(sel) > DEPTH)) begin
                    tap_vld = stage_vld[k];
                    tap_dat = stage_dat[k];
                end
            end
        end

        assign out_valid[c]                = tap_vld;
        assign out_data[c*WIDTH +: WIDTH]  = tap_dat;
        assign inflight[c*LW +: LW]        = cnt_q;
    end

endmodule

// File: tb/tb_mxn_valid_pipeline.sv
// Bench for mxn_valid_pipeline: vector table, directed corner sequences, randomized run vs queue model.
module tb_mxn_valid_pipeline;
    localparam int W  = 3;
    localparam int D  = 4;
    localparam int CH = 2;
    localparam int LW = 3;

    logic              clk      = 1'b0;
    logic              rst_n    = 1'b0;
    logic              en       = 1'b0;
    logic              flush    = 1'b0;
    logic [CH-1:0]     in_valid = '0;
    logic [CH*W-1:0]   in_data  = '0;
    logic [CH*LW-1:0]  lat_sel  = '0;
    logic [CH-1:0]     out_valid;
    logic [CH*W-1:0]   out_data;
    logic [CH*LW-1:0]  inflight;

    int checks = 0;
    int fails  = 0;

    mxn_valid_pipeline #(.WIDTH(W), .DEPTH(D), .CHANNELS(CH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .lat_sel   (lat_sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .inflight  (inflight)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic e, input logic f, input logic [CH-1:0] iv,
                       input logic [CH*W-1:0] id, input logic [CH*LW-1:0] ls);
        en       = e;
        flush    = f;
        in_valid = iv;
        in_data  = id;
        lat_sel  = ls;
    endtask

    task automatic do_reset();
        put(1'b0, 1'b0, '0, '0, '0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Vector table: inputs held across one edge, outputs expected just after it.
    typedef struct {
        bit              rst_before;
        logic            en;
        logic            flush;
        logic [CH-1:0]   iv;
        logic [CH*W-1:0] id;
        logic [CH*LW-1:0] ls;
        logic [CH-1:0]   ev;
        logic [CH*W-1:0] ed;
        logic [CH*LW-1:0] ei;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input bit r, input logic e, input logic f, input logic [CH-1:0] iv,
                           input logic [CH*W-1:0] id, input logic [CH*LW-1:0] ls,
                           input logic [CH-1:0] ev, input logic [CH*W-1:0] ed,
                           input logic [CH*LW-1:0] ei);
        vec_t v;
        v.rst_before = r; v.en = e; v.flush = f; v.iv = iv; v.id = id; v.ls = ls;
        v.ev = ev; v.ed = ed; v.ei = ei;
        vecs.push_back(v);
    endtask

    // Reference model: per channel, the last D accepted beats, newest at the back.
    typedef struct packed {
        logic         vld;
        logic [W-1:0] dat;
    } ent_t;

    ent_t mq [CH][$];

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            mq[c].delete();
            repeat (D) mq[c].push_back('0);
        end
    endtask

    task automatic model_edge();
        for (int c = 0; c < CH; c++) begin
            if (flush) begin
                for (int i = 0; i < D; i++) mq[c][i].vld = 1'b0;
            end else if (en) begin
                mq[c].push_back({in_valid[c], in_data[c*W +: W]});
                mq[c].delete(0);
            end
        end
    endtask

    function automatic int eff_tap(input int s);
        if (s == 0) return 1;
        if (s > D)  return D;
        return s;
    endfunction

    function automatic int model_count(input int c);
        int n = 0;
        for (int i = 0; i < D; i++) n += int'(mq[c][i].vld);
        return n;
    endfunction

    initial begin
        // Latency sweep: ch0 tap 4 with 5, ch1 tap 2 with 2.
        add_vec(1, 1, 0, 2'b11, {3'd2, 3'd5}, {3'd2, 3'd4}, 2'b00, {3'd0, 3'd0}, {3'd1, 3'd1});
        add_vec(0, 1, 0, 2'b00, {3'd0, 3'd0}, {3'd2, 3'd4}, 2'b10, {3'd2, 3'd0}, {3'd1, 3'd1});
        add_vec(0, 1, 0, 2'b00, {3'd0, 3'd0}, {3'd2, 3'd4}, 2'b00, {3'd0, 3'd0}, {3'd1, 3'd1});
        add_vec(0, 1, 0, 2'b00, {3'd0, 3'd0}, {3'd2, 3'd4}, 2'b01, {3'd0, 3'd5}, {3'd1, 3'd1});
        add_vec(0, 1, 0, 2'b00, {3'd0, 3'd0}, {3'd2, 3'd4}, 2'b00, {3'd0, 3'd0}, {3'd0, 3'd0});
        // Saturation: ch0 fed 10 beats (data n), tap 4.
        for (int n = 1; n <= 14; n++) begin
            logic [W-1:0]  d_in, d_exp;
            logic          v_exp;
            logic [LW-1:0] cnt;
            d_in  = (n <= 10) ? W'(n) : '0;
            v_exp = (n >= 4 && n <= 13);
            d_exp = v_exp ? W'(n - 3) : '0;
            cnt   = (n <= 10) ? LW'((n < 4) ? n : 4) : LW'(14 - n);
            add_vec(n == 1, 1, 0, {1'b0, n <= 10}, {3'd0, d_in}, {3'd0, 3'd4},
                    {1'b0, v_exp}, {3'd0, d_exp}, {3'd0, cnt});
        end

        do_reset();
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_inflight", inflight, 0);

        foreach (vecs[i]) begin
            if (vecs[i].rst_before) do_reset();
            put(vecs[i].en, vecs[i].flush, vecs[i].iv, vecs[i].id, vecs[i].ls);
            step();
            chk($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].ev);
            chk($sformatf("vec%0d_out_data", i), out_data, vecs[i].ed);
            chk($sformatf("vec%0d_inflight", i), inflight, vecs[i].ei);
        end

        // Stall: beat enters at edge 1, three stalled edges, emerges at edge 7.
        do_reset();
        put(1, 0, 2'b01, {3'd0, 3'd1}, {3'd0, 3'd4});
        step();
        chk("stall_inflight_e1", inflight, {3'd0, 3'd1});
        for (int i = 0; i < 3; i++) begin
            put(0, 0, 2'b01, {3'd0, 3'd7}, {3'd0, 3'd4});
            step();
            chk("stall_inflight_hold", inflight, {3'd0, 3'd1});
            chk("stall_out_valid", out_valid, 0);
        end
        put(1, 0, 2'b00, '0, {3'd0, 3'd4});
        for (int e = 5; e <= 7; e++) begin
            step();
            chk($sformatf("stall_out_valid_e%0d", e), out_valid[0], e == 7);
        end
        chk("stall_out_data_e7", out_data[2:0], 3'd1);

        // Flush with a coincident input beat.
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            put(1, 0, 2'b01, {3'd0, 3'(i)}, {3'd0, 3'd4});
            step();
        end
        chk("flush_pre_inflight", inflight, {3'd0, 3'd3});
        put(1, 1, 2'b01, {3'd0, 3'd7}, {3'd0, 3'd4});
        step();
        chk("flush_inflight", inflight, 0);
        chk("flush_out_valid", out_valid, 0);
        put(1, 0, 2'b00, '0, {3'd0, 3'd4});
        for (int i = 0; i < 4; i++) begin
            step();
            chk("flush_beat_lost", out_valid, 0);
            chk("flush_inflight_after", inflight, 0);
        end

        // Clamp: tap 0 -> 1 cycle, tap 7 -> 4 cycles, live tap switch.
        do_reset();
        put(1, 0, 2'b01, {3'd0, 3'd3}, {3'd0, 3'd0});
        step();
        chk("clamp0_out_valid", out_valid[0], 1);
        chk("clamp0_out_data", out_data[2:0], 3'd3);
        put(1, 0, 2'b00, '0, {3'd0, 3'd0});
        step();
        chk("clamp0_out_valid_after", out_valid[0], 0);
        do_reset();
        put(1, 0, 2'b01, {3'd0, 3'd4}, {3'd0, 3'd7});
        for (int e = 1; e <= 4; e++) begin
            step();
            chk($sformatf("clamp7_out_valid_e%0d", e), out_valid[0], e == 4);
            put(1, 0, 2'b00, '0, {3'd0, 3'd7});
        end
        chk("clamp7_out_data", out_data[2:0], 3'd4);
        do_reset();
        put(1, 0, 2'b01, {3'd0, 3'd6}, {3'd0, 3'd4});
        step();
        chk("switch_before", out_valid[0], 0);
        lat_sel = {3'd0, 3'd1};
        #1;
        chk("switch_out_valid", out_valid[0], 1);
        chk("switch_out_data", out_data[2:0], 3'd6);

        // Asynchronous reset between edges.
        do_reset();
        put(1, 0, 2'b11, {3'd3, 3'd6}, {3'd1, 3'd1});
        step();
        chk("areset_pre_valid", out_valid, 2'b11);
        #2 rst_n = 1'b0;
        #1;
        chk("areset_out_valid", out_valid, 0);
        chk("areset_out_data", out_data, 0);
        chk("areset_inflight", inflight, 0);
        @(negedge clk);
        rst_n = 1'b1;
        put(1, 0, 2'b01, {3'd0, 3'd2}, {3'd1, 3'd1});
        step();
        chk("areset_first_valid", out_valid, 2'b01);
        chk("areset_first_data", out_data, {3'd0, 3'd2});
        chk("areset_first_inflight", inflight, {3'd0, 3'd1});

        // Randomized run against the queue model.
        do_reset();
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            en       = ($urandom_range(0, 9) < 8);
            flush    = ($urandom_range(0, 19) == 0);
            in_valid = CH'($urandom);
            in_data  = (CH*W)'($urandom);
            lat_sel  = (CH*LW)'($urandom);
            @(posedge clk);
            model_edge();
            #1;
            for (int c = 0; c < CH; c++) begin
                ent_t e;
                e = mq[c][D - eff_tap(int'(lat_sel[c*LW +: LW]))];
                chk($sformatf("rnd_ch%0d_out_valid", c), out_valid[c], e.vld);
                chk($sformatf("rnd_ch%0d_out_data", c), out_data[c*W +: W], e.dat);
                chk($sformatf("rnd_ch%0d_inflight", c), inflight[c*LW +: LW], model_count(c));
            end
            if (n % 700 == 350) begin
                #2 rst_n = 1'b0;
                #1;
                chk("rnd_areset_valid", out_valid, 0);
                chk("rnd_areset_inflight", inflight, 0);
                model_reset();
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
